fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, hold buffer
// for decode stalls, branch redirect and bubble injection.
//
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   en_reg_fetch             - 1 lets the output register update
//   inject_nop               - squash: output loads a bubble
//   branch_taken/_target     - one-cycle redirect of the fetch pc
//   imem_req/imem_addr       - read request (one cycle) and address
//   imem_valid/imem_rdata    - read response strobe and data
//   instruction/pc_out       - registered instruction and its pc
//   instr_valid              - registered; 0 marks a bubble
//   block_pipe_instr_cache   - 1 when no instruction is deliverable
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_reg_fetch,
  input  logic        inject_nop,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        block_pipe_instr_cache
);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HELD,
    DROP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] hold_word;
  logic [31:0] word;
  logic [31:0] target;
  logic        have_word;
  logic        deliver;
  logic        capture;

  // A word is on hand either from a live response or the hold buffer.
  // A redirect in the same cycle makes that word wrong-path.
  assign have_word = (state == HELD)
                   | ((state == WAIT) & imem_valid);
  assign word      = (state == HELD) ? hold_word : imem_rdata;
  assign deliver   = have_word & ~branch_taken;
  assign capture   = (state == WAIT) & imem_valid
                   & ~en_reg_fetch & ~branch_taken;
  assign target    = branch_target & ~32'h3;

  assign imem_req  = (state == ISSUE) & ~reset;
  assign imem_addr = pc;

  assign block_pipe_instr_cache =
      (state == ISSUE) | (state == DROP)
    | ((state == WAIT) & ~imem_valid);

  always_comb begin
    pc_next = pc;
    if (branch_taken)
      pc_next = target;
    else if (deliver & en_reg_fetch)
      pc_next = pc + 32'd4;
  end

  // Redirect with a request still in flight must swallow its reply
  // (DROP); otherwise nothing is outstanding and we go straight on.
  always_comb begin
    state_next = state;
    unique case (state)
      ISSUE:
        state_next = branch_taken ? DROP : WAIT;
      WAIT: begin
        if (!imem_valid)
          state_next = branch_taken ? DROP : WAIT;
        else if (branch_taken || en_reg_fetch)
          state_next = ISSUE;
        else
          state_next = HELD;
      end
      HELD:
        if (branch_taken || en_reg_fetch)
          state_next = ISSUE;
      DROP:
        if (imem_valid)
          state_next = ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      hold_word   <= '0;
      instruction <= NOP_INSTR;
      pc_out      <= RESET_PC;
      instr_valid <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (capture)
        hold_word <= imem_rdata;
      else if (branch_taken)
        hold_word <= '0;
      // Bubbles keep pc_out so decode still sees the last real pc.
      if (en_reg_fetch) begin
        if (deliver && !inject_nop) begin
          instruction <= word;
          pc_out      <= pc;
          instr_valid <= 1'b1;
        end else begin
          instruction <= NOP_INSTR;
          instr_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RPC  = 32'h0000_1000;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        en_reg_fetch;
  logic        inject_nop;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        block_pipe_instr_cache;

  fetch_stage #(
    .RESET_PC (RPC),
    .NOP_INSTR(NOPW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .en_reg_fetch          (en_reg_fetch),
    .inject_nop            (inject_nop),
    .branch_taken          (branch_taken),
    .branch_target         (branch_target),
    .imem_req              (imem_req),
    .imem_addr             (imem_addr),
    .imem_valid            (imem_valid),
    .imem_rdata            (imem_rdata),
    .instruction           (instruction),
    .pc_out                (pc_out),
    .instr_valid           (instr_valid),
    .block_pipe_instr_cache(block_pipe_instr_cache)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory model
  int          mem_cnt = 0;
  logic [31:0] mem_a   = '0;

  // reference model: fetch pc, request in flight, in-flight reply
  // squashed, and one word parked while decode is stalled
  logic [31:0] m_pc;
  bit          m_pend;
  bit          m_sq;
  bit          m_bufv;
  logic [31:0] m_bufw;
  logic [31:0] e_ins;
  logic [31:0] e_pco;
  logic        e_iv;
  logic        e_req;
  logic [31:0] e_addr;
  logic        e_blk;

  // observations
  logic        o_req;
  logic [31:0] o_addr;
  logic        o_blk;
  logic [31:0] o_ins;
  logic [31:0] o_pco;
  logic        o_iv;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC3C3_0000;
  endfunction

  // One clock cycle: drive inputs, sample combinational outputs,
  // advance the model across the edge, sample registered outputs.
  task automatic cycle(input bit r, input bit en, input bit nop,
                       input bit br, input logic [31:0] tgt,
                       input int lat);
    bit          w_av;
    logic [31:0] w;
    reset         = r;
    en_reg_fetch  = en;
    inject_nop    = nop;
    branch_taken  = br;
    branch_target = tgt;
    imem_valid    = 1'b0;
    imem_rdata    = $urandom;
    if (r) begin
      mem_cnt = 0;
    end else if (mem_cnt == 1) begin
      imem_valid = 1'b1;
      imem_rdata = memw(mem_a);
    end
    if (mem_cnt > 0) mem_cnt--;
    if (r) begin
      e_req  = 1'b0;
      e_addr = m_pc;
      e_blk  = 1'b1;
    end else begin
      e_req  = !m_pend && !m_bufv;
      e_addr = m_pc;
      e_blk  = e_req || (m_pend && (m_sq || !imem_valid));
    end
    #2;
    o_req  = imem_req;
    o_addr = imem_addr;
    o_blk  = block_pipe_instr_cache;
    @(posedge clk);
    if (o_req && !r) begin
      mem_cnt = lat;
      mem_a   = o_addr;
    end
    if (r) begin
      m_pc   = RPC;
      m_pend = 0;
      m_sq   = 0;
      m_bufv = 0;
      m_bufw = '0;
      e_ins  = NOPW;
      e_pco  = RPC;
      e_iv   = 1'b0;
    end else begin
      w_av = (m_pend && !m_sq && imem_valid) || m_bufv;
      w    = m_bufv ? m_bufw : imem_rdata;
      if (en) begin
        if (w_av && !br && !nop) begin
          e_ins = w;
          e_pco = m_pc;
          e_iv  = 1'b1;
        end else begin
          e_ins = NOPW;
          e_iv  = 1'b0;
        end
      end
      if (e_req) begin
        m_pend = 1;
        m_sq   = br;
      end else if (m_pend) begin
        if (imem_valid) m_pend = 0;
        else if (br) m_sq = 1;
      end
      if (w_av && !br) begin
        if (en) begin
          m_pc   = m_pc + 32'd4;
          m_bufv = 0;
        end else begin
          m_bufv = 1;
          m_bufw = w;
        end
      end else if (br) begin
        m_bufv = 0;
      end
      if (br) m_pc = tgt & ~32'h3;
    end
    #1;
    o_ins = instruction;
    o_pco = pc_out;
    o_iv  = instr_valid;
  endtask

  task automatic test_reset();
    cycle(1, 1, 0, 1, 32'h55, 1);
    total++;
    if (o_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_req got=%0b want=0", o_req);
    end
    cycle(1, 0, 0, 0, 0, 1);
    total++;
    if (o_ins !== NOPW) begin
      bad++;
      $display("FAIL reset_ins got=%h want=%h", o_ins, NOPW);
    end
    total++;
    if (o_pco !== RPC) begin
      bad++;
      $display("FAIL reset_pc got=%h want=%h", o_pco, RPC);
    end
    total++;
    if (o_iv !== 1'b0) begin
      bad++;
      $display("FAIL reset_iv got=%0b want=0", o_iv);
    end
    cycle(0, 1, 0, 0, 0, 1);
    total++;
    if (o_req !== 1'b1 || o_addr !== RPC) begin
      bad++;
      $display("FAIL first_req got=%0b/%h want=1/%h",
               o_req, o_addr, RPC);
    end
  endtask

  task automatic test_steady();
    logic [31:0] a;
    cycle(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 0, 0, 0, 1);
      a = RPC + 32'(4 * (i / 2));
      total++;
      if (i % 2 == 0) begin
        if (o_req !== 1'b1 || o_addr !== a) begin
          bad++;
          $display("FAIL steady_req i=%0d got=%0b/%h want=1/%h",
                   i, o_req, o_addr, a);
        end
      end else begin
        if (o_req !== 1'b0 || o_iv !== 1'b1 || o_pco !== a
            || o_ins !== memw(a)) begin
          bad++;
          $display("FAIL steady_out i=%0d got=%0b/%0b/%h/%h want=0/1/%h/%h",
                   i, o_req, o_iv, o_pco, o_ins, a, memw(a));
        end
      end
    end
  endtask

  task automatic test_held();
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      total++;
      if (o_blk !== 1'b0 || o_req !== 1'b0 || o_iv !== 1'b0
          || o_ins !== NOPW || o_pco !== RPC) begin
        bad++;
        $display("FAIL held_frozen got=%0b/%0b/%0b/%h/%h want=0/0/0/%h/%h",
                 o_blk, o_req, o_iv, o_ins, o_pco, NOPW, RPC);
      end
    end
    cycle(0, 1, 0, 0, 0, 1);
    total++;
    if (o_iv !== 1'b1 || o_pco !== RPC || o_ins !== memw(RPC)) begin
      bad++;
      $display("FAIL held_load got=%0b/%h/%h want=1/%h/%h",
               o_iv, o_pco, o_ins, RPC, memw(RPC));
    end
    cycle(0, 1, 0, 0, 0, 1);
    total++;
    if (o_req !== 1'b1 || o_addr !== RPC + 32'd4) begin
      bad++;
      $display("FAIL held_next got=%0b/%h want=1/%h",
               o_req, o_addr, RPC + 32'd4);
    end
  endtask

  task automatic test_branch_wait();
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 3);
    cycle(0, 1, 0, 1, 32'h0000_2000, 1);
    cycle(0, 1, 0, 0, 0, 1);
    total++;
    if (o_blk !== 1'b1) begin
      bad++;
      $display("FAIL drop_block got=%0b want=1", o_blk);
    end
    cycle(0, 1, 0, 0, 0, 1);
    total++;
    if (o_iv !== 1'b0) begin
      bad++;
      $display("FAIL drop_iv got=%0b want=0", o_iv);
    end
    cycle(0, 1, 0, 0, 0, 1);
    total++;
    if (o_req !== 1'b1 || o_addr !== 32'h0000_2000 || o_iv !== 1'b0)
    begin
      bad++;
      $display("FAIL drop_redirect got=%0b/%h/%0b want=1/00002000/0",
               o_req, o_addr, o_iv);
    end
  endtask

  task automatic test_inject_nop();
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 1);
    total++;
    if (o_ins !== NOPW || o_iv !== 1'b0 || o_pco !== RPC) begin
      bad++;
      $display("FAIL nop_out got=%h/%0b/%h want=%h/0/%h",
               o_ins, o_iv, o_pco, NOPW, RPC);
    end
    cycle(0, 1, 0, 0, 0, 1);
    total++;
    if (o_req !== 1'b1 || o_addr !== RPC + 32'd4) begin
      bad++;
      $display("FAIL nop_advance got=%0b/%h want=1/%h",
               o_req, o_addr, RPC + 32'd4);
    end
  endtask

  task automatic test_wrap();
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 1, 32'hFFFF_FFFE, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    total++;
    if (o_req !== 1'b1 || o_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_target got=%0b/%h want=1/fffffffc",
               o_req, o_addr);
    end
    cycle(0, 1, 0, 0, 0, 1);
    total++;
    if (o_iv !== 1'b1 || o_pco !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_load got=%0b/%h want=1/fffffffc",
               o_iv, o_pco);
    end
    cycle(0, 1, 0, 0, 0, 1);
    total++;
    if (o_req !== 1'b1 || o_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_zero got=%0b/%h want=1/00000000",
               o_req, o_addr);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 5);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 1);
    total++;
    if (o_req !== 1'b0 || o_ins !== NOPW || o_pco !== RPC
        || o_iv !== 1'b0) begin
      bad++;
      $display("FAIL midreset_out got=%0b/%h/%h/%0b want=0/%h/%h/0",
               o_req, o_ins, o_pco, o_iv, NOPW, RPC);
    end
    cycle(0, 1, 0, 0, 0, 2);
    total++;
    if (o_req !== 1'b1 || o_addr !== RPC) begin
      bad++;
      $display("FAIL midreset_req got=%0b/%h want=1/%h",
               o_req, o_addr, RPC);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0, 0, 2);
      total++;
      if (o_iv !== e_iv || o_pco !== e_pco || o_ins !== e_ins) begin
        bad++;
        $display("FAIL midreset_after i=%0d got=%0b/%h want=%0b/%h",
                 i, o_iv, o_pco, e_iv, e_pco);
      end
    end
  endtask

  task automatic test_random();
    bit          r;
    bit          en;
    bit          nop;
    bit          br;
    logic [31:0] tgt;
    cycle(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(63) == 0);
      en  = ($urandom_range(9) < 7);
      nop = ($urandom_range(7) == 0);
      br  = ($urandom_range(9) == 0);
      tgt = $urandom;
      cycle(r, en, nop, br, tgt, int'($urandom_range(4, 1)));
      if (!r) begin
        total++;
        if (o_req !== e_req || (e_req && o_addr !== e_addr)) begin
          bad++;
          $display("FAIL rnd_req i=%0d got=%0b/%h want=%0b/%h",
                   i, o_req, o_addr, e_req, e_addr);
        end
        total++;
        if (o_blk !== e_blk) begin
          bad++;
          $display("FAIL rnd_block i=%0d got=%0b want=%0b",
                   i, o_blk, e_blk);
        end
      end
      total++;
      if (o_ins !== e_ins || o_pco !== e_pco || o_iv !== e_iv) begin
        bad++;
        $display("FAIL rnd_out i=%0d got=%h/%h/%0b want=%h/%h/%0b",
                 i, o_ins, o_pco, o_iv, e_ins, e_pco, e_iv);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    en_reg_fetch  = 1'b0;
    inject_nop    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_valid    = 1'b0;
    imem_rdata    = '0;
    m_pc          = RPC;
    m_pend        = 0;
    m_sq          = 0;
    m_bufv        = 0;
    m_bufw        = '0;
    e_ins         = NOPW;
    e_pco         = RPC;
    e_iv          = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_steady();
    test_held();
    test_branch_wait();
    test_inject_nop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
